data_memory_ctrl: RTL and testbench

Parametrised data-memory controller that replaces the flat doubleword array in the single-cycle datapath. It serves one load/store request at a time over a valid/ready handshake with configurable access latency. It supports byte, half, word and double sizes with sign/zero extension and reports misaligned or out-of-range accesses. It sits between the execute stage (address from the ALU) and the write-back mux, and it is the memory block for the upcoming multi-cycle core.

---
 rtl/data_memory_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl
// Purpose  : Single-request load/store data memory with valid/ready handshake,
//            fixed access latency, sized/extended accesses and error reporting.
//            Optional DMEM_CLEAR_ON_RESET_EN zero-fills memory after reset.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
   parameter int XLEN    = 64,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_err
);
   localparam int            c_BYTES    = XLEN / 8;
   localparam int            c_LANE_W   = $clog2(c_BYTES);
   localparam int            c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [XLEN:0] c_LIMIT    = (XLEN+1)'(DEPTH) * (XLEN+1)'(c_BYTES);
   localparam logic [3:0]    c_CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_WAIT = 2'd1;
   localparam logic [1:0] c_RESP = 2'd2;
`ifdef DMEM_CLEAR_ON_RESET_EN
   localparam logic [1:0] c_CLEAR       = 2'd3;
   localparam logic [1:0] c_RESET_STATE = c_CLEAR;
   logic [c_IDX_W-1:0]    r_clr_idx;
`else
   localparam logic [1:0] c_RESET_STATE = c_IDLE;
`endif

   logic [1:0]      r_state;
   logic [3:0]      r_cnt;
   logic            r_write;
   logic [1:0]      r_size;
   logic            r_unsigned;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic [XLEN-1:0] r_mem [DEPTH];

   logic                w_accept;
   logic [c_LANE_W-1:0] w_lane;
   logic [c_IDX_W-1:0]  w_idx;
   logic [XLEN-1:0]     w_word;
   logic [XLEN-1:0]     w_shifted;
   logic [XLEN-1:0]     w_wdata_sh;
   logic [XLEN-1:0]     w_mask;
   logic [XLEN-1:0]     w_load;
   logic [c_BYTES-1:0]  w_be_base;
   logic [c_BYTES-1:0]  w_be;
   logic                w_sign;
   logic                w_misalign;
   logic                w_oor;
   logic                w_badsize;
   logic                w_err;
   logic                w_store;

   assign req_ready = (r_state == c_IDLE);
   assign w_accept  = req_valid && req_ready;

   // All decode works on the latched request, never on the live inputs
   assign w_lane     = r_addr[c_LANE_W-1:0];
   assign w_idx      = r_addr[c_LANE_W +: c_IDX_W];
   assign w_word     = r_mem[w_idx];
   assign w_shifted  = w_word >> {w_lane, 3'b000};
   assign w_wdata_sh = r_wdata << {w_lane, 3'b000};
   assign w_be       = w_be_base << w_lane;

   always_comb begin
      w_mask     = '1;
      w_sign     = w_shifted[XLEN-1];
      w_be_base  = '1;
      w_misalign = 1'b0;
      case (r_size)
         2'd0: begin
            w_mask    = XLEN'(8'hFF);
            w_sign    = w_shifted[7];
            w_be_base = c_BYTES'(1);
         end
         2'd1: begin
            w_mask     = XLEN'(16'hFFFF);
            w_sign     = w_shifted[15];
            w_be_base  = c_BYTES'(2'b11);
            w_misalign = r_addr[0];
         end
         2'd2: begin
            w_mask     = XLEN'(32'hFFFF_FFFF);
            w_sign     = w_shifted[31];
            w_be_base  = c_BYTES'(4'hF);
            w_misalign = |r_addr[1:0];
         end
         default: begin
            w_misalign = |r_addr[2:0];
         end
      endcase
   end

   // A full-width mask leaves ~w_mask at zero, so the unsigned flag drops out
   assign w_load    = (w_shifted & w_mask) | ((w_sign && !r_unsigned) ? ~w_mask : '0);
   assign w_oor     = ({1'b0, r_addr} >= c_LIMIT);
   assign w_badsize = (r_size == 2'd3) && (XLEN == 32);
   assign w_err     = w_misalign || w_oor || w_badsize;
   assign w_store   = (r_state == c_RESP) && r_write && !w_err;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= c_RESET_STATE;
         r_cnt      <= 4'd0;
         r_write    <= 1'b0;
         r_size     <= 2'd0;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
`ifdef DMEM_CLEAR_ON_RESET_EN
         r_clr_idx  <= '0;
`endif
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  r_write    <= req_write;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  r_cnt      <= c_CNT_INIT;
                  r_state    <= (LATENCY > 0) ? c_WAIT : c_RESP;
               end
            end
            c_WAIT: begin
               if (r_cnt == 4'd0) r_state <= c_RESP;
               else               r_cnt   <= r_cnt - 4'd1;
            end
            c_RESP: r_state <= c_IDLE;
`ifdef DMEM_CLEAR_ON_RESET_EN
            c_CLEAR: begin
               if (r_clr_idx == c_IDX_W'(DEPTH - 1)) r_state   <= c_IDLE;
               else                                  r_clr_idx <= r_clr_idx + c_IDX_W'(1);
            end
`endif
            default: r_state <= c_IDLE;
         endcase
      end
   end

   // Response is registered at the edge that ends RESP
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= (r_state == c_RESP);
         if (r_state == c_RESP) begin
            resp_err   <= w_err;
            resp_rdata <= (r_write || w_err) ? '0 : w_load;
         end
      end
   end

   always_ff @(posedge clock) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
      if (r_state == c_CLEAR) r_mem[r_clr_idx] <= '0;
`endif
      if (w_store) begin
         for (int i = 0; i < c_BYTES; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_ctrl
// Purpose  : Directed bench for data_memory_ctrl (LATENCY=1 and LATENCY=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;
   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, reset3;
   logic [1:0]  req_valid, req_ready, resp_valid, resp_err;
   logic        req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [63:0] req_addr, req_wdata, rdata0, rdata1;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [5:0]  hist_r, hist_v;

   data_memory_ctrl #(.XLEN(64), .DEPTH(1024), .LATENCY(1)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[0]),
      .resp_rdata(rdata0), .resp_err(resp_err[0]));

   data_memory_ctrl #(.XLEN(64), .DEPTH(1024), .LATENCY(3)) dut3 (
      .clock(clock), .reset(reset3), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid[1]),
      .resp_rdata(rdata1), .resp_err(resp_err[1]));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One complete transaction on instance s; inputs are scrambled after acceptance
   task automatic xact(input int s, input logic w, input logic [1:0] sz, input logic u,
                       input logic [63:0] a, input logic [63:0] d,
                       input logic [63:0] exp_rd, input logic exp_err, input string tag);
      int n;
      int lat;
      req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
      req_valid[s] = 1'b1;
      n = 0;
      while (!req_ready[s] && n < 100) begin tick(); n++; end
      check({tag, " ready"}, 64'(req_ready[s]), 64'd1);
      tick();
      req_valid[s] = 1'b0;
      req_write = ~w; req_size = ~sz; req_unsigned = ~u; req_addr = ~a; req_wdata = ~d;
      lat = 0;
      while (!resp_valid[s] && lat < 100) begin tick(); lat++; end
      check({tag, " latency"}, 64'(lat), (s == 0) ? 64'd2 : 64'd4);
      check({tag, " rdata"}, (s == 0) ? rdata0 : rdata1, exp_rd);
      check({tag, " err"}, 64'(resp_err[s]), 64'(exp_err));
      tick();
      check({tag, " pulse"}, 64'(resp_valid[s]), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; reset3 = 1'b1; req_valid = 2'b00;
      req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (3) tick();
      reset = 1'b0; reset3 = 1'b0;
      tick();
      check("rst ready", 64'(req_ready[0]), 64'd1);
      check("rst valid", 64'(resp_valid[0]), 64'd0);
      check("rst err", 64'(resp_err[0]), 64'd0);
      check("rst rdata", rdata0, 64'd0);
      check("rst3 ready", 64'(req_ready[1]), 64'd1);

      xact(0, 1, 2'd3, 0, 64'h10, 64'h1122334455667788, 64'h0, 0, "SD 0x10");
      xact(0, 0, 2'd3, 0, 64'h10, 64'h0, 64'h1122334455667788, 0, "LD 0x10");
      xact(0, 0, 2'd0, 0, 64'h17, 64'h0, 64'h11, 0, "LB 0x17");
      xact(0, 0, 2'd2, 0, 64'h14, 64'h0, 64'h11223344, 0, "LW 0x14");
      xact(0, 1, 2'd0, 0, 64'h10, 64'hCAFEBABEDEADBE80, 64'h0, 0, "SB 0x10");
      xact(0, 0, 2'd0, 0, 64'h10, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, "LB 0x10");
      xact(0, 0, 2'd0, 1, 64'h10, 64'h0, 64'h80, 0, "LBU 0x10");
      xact(0, 0, 2'd3, 0, 64'h10, 64'h0, 64'h1122334455667780, 0, "LD after SB");
      xact(0, 1, 2'd1, 0, 64'h12, 64'h000000000000BEEF, 64'h0, 0, "SH 0x12");
      xact(0, 0, 2'd2, 0, 64'h10, 64'h0, 64'hFFFFFFFFBEEF7780, 0, "LW 0x10");
      xact(0, 0, 2'd2, 1, 64'h10, 64'h0, 64'h00000000BEEF7780, 0, "LWU 0x10");
      xact(0, 0, 2'd1, 0, 64'h16, 64'h0, 64'h1122, 0, "LH 0x16");
      xact(0, 0, 2'd1, 0, 64'h12, 64'h0, 64'hFFFFFFFFFFFFBEEF, 0, "LH 0x12");
      xact(0, 0, 2'd1, 1, 64'h12, 64'h0, 64'hBEEF, 0, "LHU 0x12");
      xact(0, 0, 2'd2, 0, 64'h12, 64'h0, 64'h0, 1, "LW misaligned");
      xact(0, 0, 2'd1, 0, 64'h11, 64'h0, 64'h0, 1, "LH misaligned");
      xact(0, 1, 2'd3, 0, 64'h1FF8, 64'h0123456789ABCDEF, 64'h0, 0, "SD 0x1FF8");
      xact(0, 1, 2'd3, 0, 64'h2000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, "SD 0x2000");
      xact(0, 0, 2'd3, 0, 64'h1FF8, 64'h0, 64'h0123456789ABCDEF, 0, "LD 0x1FF8");
      xact(0, 1, 2'd3, 0, 64'h2010, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, "SD 0x2010");
      xact(0, 0, 2'd3, 0, 64'h10, 64'h0, 64'h11223344BEEF7780, 0, "LD no alias");

      // Two loads with req_valid held: accepts at edges 0 and 3, pulses after edges 2 and 5
      req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'h1FF8;
      req_valid[0] = 1'b1;
      hist_r = '0; hist_v = '0;
      for (int k = 0; k < 6; k++) begin
         tick();
         hist_r[k] = req_ready[0];
         hist_v[k] = resp_valid[0];
         if (k == 0) req_addr = 64'h10;
         if (k == 2) check("hold rdata1", rdata0, 64'h0123456789ABCDEF);
         if (k == 3) req_valid[0] = 1'b0;
         if (k == 5) check("hold rdata2", rdata0, 64'h11223344BEEF7780);
      end
      check("hold ready", 64'(hist_r), 64'b100100);
      check("hold valid", 64'(hist_v), 64'b100100);
      tick();

      // Reset during WAIT on the LATENCY=3 instance discards the store
      xact(1, 1, 2'd3, 0, 64'h0, 64'h5555, 64'h0, 0, "L3 SD 0x0");
      req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
      req_addr = 64'h0; req_wdata = 64'hAA;
      req_valid[1] = 1'b1;
      tick();
      req_valid[1] = 1'b0;
      tick();
      check("L3 wait ready", 64'(req_ready[1]), 64'd0);
      reset3 = 1'b1;
      #1;
      check("L3 rst ready", 64'(req_ready[1]), 64'd1);
      check("L3 rst valid", 64'(resp_valid[1]), 64'd0);
      repeat (2) tick();
      reset3 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("L3 no pulse", 64'(resp_valid[1]), 64'd0);
      end
      xact(1, 0, 2'd3, 0, 64'h0, 64'h0, 64'h5555, 0, "L3 LD after rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
